gpr_dump_reader: RTL and testbench

Debug read-out engine for the general-purpose register file. On a start pulse it walks the register file's read port from register 0 to register 31. It captures each value and presents it on a valid/ready output channel as an address/data pair. It sits beside the datapath, owns one read port of the register file, and feeds the testbench or a debug/trace sink for end-of-program register dumps.

---
 rtl/gpr_dump_reader.sv | 111 +++++++++++
 tb/tb_gpr_dump_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_dump_reader.sv
// Walks the register-file read port from index 0 upward and emits each captured
// register as an address/data pair on a valid/ready channel.
module gpr_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              skip_zero_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   emit_count_o
);

  typedef enum logic [1:0] {StIdle, StRead, StHold, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                skip_q, skip_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W:0]     emit_count_q, emit_count_d;
  logic                last_idx;

  assign last_idx = (idx_q == ADDR_W'(NUM_REGS - 1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    skip_d       = skip_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    emit_count_d = emit_count_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d        = '0;
          skip_d       = skip_zero_i;
          emit_count_d = '0;
          state_d      = StRead;
        end
      end
      StRead: begin
        // Capture happens every READ cycle; a skipped zero is simply never made valid.
        out_addr_d = idx_q;
        out_data_d = rd_data_i;
        if (skip_q && (rd_data_i == '0)) begin
          if (last_idx) begin
            state_d = StFin;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          emit_count_d = emit_count_q + 1'b1;
          if (last_idx) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      skip_q       <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      emit_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      skip_q       <= skip_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      emit_count_q <= emit_count_d;
    end
  end

  assign rd_addr_o    = idx_q;
  assign out_valid_o  = (state_q == StHold);
  assign out_addr_o   = out_addr_q;
  assign out_data_o   = out_data_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StFin);
  assign emit_count_o = emit_count_q;

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Bench for gpr_dump_reader: register file array, handshake monitor and a list model of
// the expected dump derived from register contents and the skip rule.
module tb_gpr_dump_reader;
  localparam int N = 32;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, skip_zero_i, out_ready_i;
  logic [4:0]  rd_addr_o, out_addr_o;
  logic [31:0] rd_data_i, out_data_o;
  logic        out_valid_o, busy_o, done_o;
  logic [5:0]  emit_count_o;

  logic [31:0] rf [N];
  int checks = 0;
  int errors = 0;

  gpr_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .skip_zero_i(skip_zero_i),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_addr_o(out_addr_o), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o), .emit_count_o(emit_count_o)
  );

  always #5 clk_i = ~clk_i;
  assign rd_data_i = rf[rd_addr_o];

  // Monitor: accepted pairs, done pulses, busy cycles, valid/data stability violations.
  logic [36:0] got[$];
  int          done_cnt = 0, busy_cyc = 0, stab_err = 0;
  logic        pv = 1'b0, phs = 1'b0;
  logic [4:0]  pa = '0;
  logic [31:0] pd = '0;

  always @(negedge clk_i) begin
    if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    if (busy_o === 1'b1) busy_cyc <= busy_cyc + 1;
    if (!reset_i && pv && !phs && (out_valid_o !== 1'b1 || out_addr_o !== pa || out_data_o !== pd))
      stab_err <= stab_err + 1;
    if (!reset_i && out_valid_o && out_ready_i) got.push_back({out_addr_o, out_data_o});
    pv  <= !reset_i && (out_valid_o === 1'b1);
    phs <= out_ready_i;
    pa  <= out_addr_o;
    pd  <= out_data_o;
  end

  logic [36:0] exp_q[$];
  int gb, db, bb, sb;
  bit timed_out;

  function automatic void build_exp(input bit skip);
    logic [4:0] a;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      a = i[4:0];
      if (!(skip && rf[i] == 32'h0)) exp_q.push_back({a, rf[i]});
    end
  endfunction

  // mode 0: ready held 1; 1: random ready; 2: random ready plus 10-cycle stall on reg 7
  task automatic run_dump(input bit skip, input int mode, input int restart_at, input bit do_write);
    int hold_left = 0;
    bit held7 = 0, restarted = 0, written = 0;
    gb = got.size(); db = done_cnt; bb = busy_cyc; sb = stab_err;
    timed_out = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b1; skip_zero_i = skip;
    out_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done_cnt != db) begin
        timed_out = 1'b0;
        break;
      end
      if (mode == 2 && !held7 && out_valid_o && out_addr_o == 5'd7) begin
        held7 = 1; hold_left = 10;
      end
      if (mode == 0) out_ready_i = 1'b1;
      else if (hold_left > 0) begin
        out_ready_i = 1'b0; hold_left--;
      end else out_ready_i = 1'($urandom_range(0, 1));
      start_i = 1'b0;
      if (restart_at >= 0 && !restarted && out_valid_o && out_addr_o == 5'(restart_at)) begin
        start_i = 1'b1; restarted = 1;
      end
      if (do_write && !written && out_valid_o && out_addr_o == 5'd5) begin
        rf[5] = 32'h12345678; rf[25] = 32'h12345678; written = 1;
      end
      skip_zero_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
    end
    start_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL reset_rd_addr got %h exp 0", rd_addr_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
    checks++; if (out_addr_o !== 5'd0) begin errors++; $display("FAIL reset_out_addr got %h exp 0", out_addr_o); end
    checks++; if (out_data_o !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (emit_count_o !== 6'd0) begin errors++; $display("FAIL reset_emit got %0d exp 0", emit_count_o); end
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < N; i++) rf[i] = i * 32'h01010101;
    build_exp(1'b0);
    run_dump(1'b0, 0, -1, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL full_timeout got none exp done"); end
    checks++; if (got.size() - gb !== 32) begin errors++; $display("FAIL full_count got %0d exp 32", got.size() - gb); end
    for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL full_pair[%0d] got %h exp %h", i, got[gb+i], exp_q[i]); end
    end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL full_done got %0d exp 1", done_cnt - db); end
    checks++; if (emit_count_o !== 6'd32) begin errors++; $display("FAIL full_emit got %0d exp 32", emit_count_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b exp 0", busy_o); end
    checks++; if (busy_cyc - bb !== 65) begin errors++; $display("FAIL full_busy_cycles got %0d exp 65", busy_cyc - bb); end
  endtask

  task automatic test_skip_zero();
    for (int i = 0; i < N; i++) rf[i] = 32'h0;
    rf[3] = 32'hDEADBEEF; rf[31] = 32'h00000001;
    run_dump(1'b1, 0, -1, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL skip_timeout got none exp done"); end
    checks++; if (got.size() - gb !== 2) begin errors++; $display("FAIL skip_count got %0d exp 2", got.size() - gb); end
    if (got.size() - gb >= 2) begin
      checks++; if (got[gb] !== {5'd3, 32'hDEADBEEF}) begin errors++; $display("FAIL skip_pair0 got %h exp %h", got[gb], {5'd3, 32'hDEADBEEF}); end
      checks++; if (got[gb+1] !== {5'd31, 32'h1}) begin errors++; $display("FAIL skip_pair1 got %h exp %h", got[gb+1], {5'd31, 32'h1}); end
    end
    checks++; if (emit_count_o !== 6'd2) begin errors++; $display("FAIL skip_emit got %0d exp 2", emit_count_o); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL skip_done got %0d exp 1", done_cnt - db); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    build_exp(1'b0);
    run_dump(1'b0, 2, -1, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got none exp done"); end
    checks++; if (got.size() - gb !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got.size() - gb, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL bp_pair[%0d] got %h exp %h", i, got[gb+i], exp_q[i]); end
    end
    checks++; if (stab_err - sb !== 0) begin errors++; $display("FAIL bp_stability got %0d exp 0", stab_err - sb); end
    checks++; if (emit_count_o !== 6'd32) begin errors++; $display("FAIL bp_emit got %0d exp 32", emit_count_o); end
  endtask

  task automatic test_restart_ignored();
    bit skip = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) rf[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
    rf[12] = 32'hC0DE0012;
    build_exp(skip);
    run_dump(skip, 1, 12, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL restart_timeout got none exp done"); end
    checks++; if (got.size() - gb !== exp_q.size()) begin errors++; $display("FAIL restart_count got %0d exp %0d", got.size() - gb, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL restart_pair[%0d] got %h exp %h", i, got[gb+i], exp_q[i]); end
    end
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL restart_done got %0d exp 1", done_cnt - db); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL restart_busy got %b exp 0", busy_o); end
    checks++; if (emit_count_o !== 6'(exp_q.size())) begin errors++; $display("FAIL restart_emit got %0d exp %0d", emit_count_o, exp_q.size()); end
  endtask

  task automatic test_async_reset();
    bit reached = 0;
    int d0;
    for (int i = 0; i < N; i++) rf[i] = $urandom | 32'h1;
    d0 = done_cnt;
    @(posedge clk_i); #1;
    start_i = 1'b1; skip_zero_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (out_valid_o && out_addr_o == 5'd20) begin
        reached = 1;
        break;
      end
      out_ready_i = (rd_addr_o != 5'd20);
      @(posedge clk_i); #1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL arst_reach_hold20 got no exp yes"); end
    #1 reset_i = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", out_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy_o); end
    checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL arst_rd_addr got %h exp 0", rd_addr_o); end
    checks++; if (emit_count_o !== 6'd0) begin errors++; $display("FAIL arst_emit got %0d exp 0", emit_count_o); end
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL arst_no_done got %0d exp %0d", done_cnt, d0); end
    build_exp(1'b0);
    run_dump(1'b0, 0, -1, 1'b0);
    checks++; if (got.size() - gb !== 32) begin errors++; $display("FAIL arst_redump_count got %0d exp 32", got.size() - gb); end
    for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL arst_pair[%0d] got %h exp %h", i, got[gb+i], exp_q[i]); end
    end
  endtask

  task automatic test_snapshot();
    for (int i = 0; i < N; i++) rf[i] = $urandom | 32'h1;
    rf[5] = 32'hA5A5_0005; rf[25] = 32'h5A5A_0025;
    build_exp(1'b0);
    exp_q[25] = {5'd25, 32'h12345678};
    run_dump(1'b0, 0, -1, 1'b1);
    checks++; if (timed_out) begin errors++; $display("FAIL snap_timeout got none exp done"); end
    checks++; if (got.size() - gb !== 32) begin errors++; $display("FAIL snap_count got %0d exp 32", got.size() - gb); end
    for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
      checks++;
      if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL snap_pair[%0d] got %h exp %h", i, got[gb+i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) rf[i] = 32'h0;
    reset_i = 1'b1; start_i = 1'b0; skip_zero_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    test_reset();
    @(posedge clk_i); #1 reset_i = 1'b0;
    test_reset();
    test_full_dump();
    test_skip_zero();
    test_backpressure();
    test_restart_ignored();
    test_async_reset();
    test_snapshot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
